// File: rtl/test_status_responder.sv
// -----------------------------------------------------------------------------
// test_status_responder
//
// Terminates CPU load/store requests aimed at a 32-byte register window and
// turns them into end-of-test status: 64-bit pass/fail bitmaps, a sticky done
// flag with a 24-bit exit code, a scratch register, a read-only ID and a
// free-running cycle counter that freezes when done sets.
//
// Ports
//   i_clk            clock (rising edge)
//   i_rst            synchronous active-high reset
//   i_bus_data       store data, right-aligned
//   i_bus_address    byte address
//   i_bus_DV         request valid (a rising edge starts a request)
//   i_bhw            access size one-hot: 001 byte, 010 half, else word
//   i_write_notread  1 = store, 0 = load
//   o_bus_data       load data, right-aligned, zero-extended; 0 otherwise
//   o_bus_DV         one-cycle acknowledge
//   o_test_pass      PASS & ~FAIL
//   o_done           sticky done flag
//   o_exit_code      code captured with done
//   o_cycles         cycle counter
// -----------------------------------------------------------------------------
module test_status_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_F000,
  parameter logic [31:0] ID_VALUE  = 32'h5445_5354
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_bus_data,
  input  logic [31:0] i_bus_address,
  input  logic        i_bus_DV,
  input  logic [2:0]  i_bhw,
  input  logic        i_write_notread,
  output logic [31:0] o_bus_data,
  output logic        o_bus_DV,
  output logic [63:0] o_test_pass,
  output logic        o_done,
  output logic [23:0] o_exit_code,
  output logic [31:0] o_cycles
);

  localparam int DATA_W = 32;

  // Lane mask for the access size, positioned at the lane's bit offset.
  function automatic logic [DATA_W-1:0] lane_mask(input logic is_byte,
                                                  input logic is_half,
                                                  input logic [4:0] shamt);
    logic [DATA_W-1:0] m;
    if (is_byte)      m = 32'h0000_00FF;
    else if (is_half) m = 32'h0000_FFFF;
    else              m = 32'hFFFF_FFFF;
    return m << shamt;
  endfunction

  logic              dv_prev_q;
  logic              ack_q,      ack_d;
  logic [DATA_W-1:0] rdata_q,    rdata_d;
  logic [DATA_W-1:0] pass_lo_q,  pass_lo_d;
  logic [DATA_W-1:0] pass_hi_q,  pass_hi_d;
  logic [DATA_W-1:0] fail_lo_q,  fail_lo_d;
  logic [DATA_W-1:0] fail_hi_q,  fail_hi_d;
  logic [DATA_W-1:0] scratch_q,  scratch_d;
  logic [DATA_W-1:0] cycles_q,   cycles_d;
  logic              done_q,     done_d;
  logic [23:0]       code_q,     code_d;
  logic [63:0]       tpass_q,    tpass_d;

  logic              start, hit, req, is_byte, is_half, misal, wr_en;
  logic [4:0]        shamt;
  logic [2:0]        off;
  logic [DATA_W-1:0] mask, lane_wdata, rd_full, rd_lane;

  always_comb begin
    start   = i_bus_DV & ~dv_prev_q;
    hit     = (i_bus_address[31:5] == BASE_ADDR[31:5]);
    req     = start & hit;
    off     = i_bus_address[4:2];
    is_byte = (i_bhw == 3'b001);
    is_half = (i_bhw == 3'b010);
    misal   = is_half ? i_bus_address[0]
                      : (!is_byte && (i_bus_address[1:0] != 2'b00));
    if (is_byte)      shamt = {i_bus_address[1:0], 3'b000};
    else if (is_half) shamt = {i_bus_address[1], 4'b0000};
    else              shamt = 5'd0;
    mask       = lane_mask(is_byte, is_half, shamt);
    lane_wdata = (i_bus_data << shamt) & mask;
    wr_en      = req & i_write_notread & ~misal;

    case (off)
      3'd0:    rd_full = pass_lo_q;
      3'd1:    rd_full = pass_hi_q;
      3'd2:    rd_full = fail_lo_q;
      3'd3:    rd_full = fail_hi_q;
      3'd4:    rd_full = {code_q, 7'b0, done_q};
      3'd5:    rd_full = cycles_q;
      3'd6:    rd_full = scratch_q;
      default: rd_full = ID_VALUE;
    endcase
    rd_lane = (rd_full & mask) >> shamt;

    pass_lo_d = pass_lo_q;
    pass_hi_d = pass_hi_q;
    fail_lo_d = fail_lo_q;
    fail_hi_d = fail_hi_q;
    scratch_d = scratch_q;
    done_d    = done_q;
    code_d    = code_q;
    if (wr_en) begin
      case (off)
        3'd0: pass_lo_d = pass_lo_q | lane_wdata;
        3'd1: pass_hi_d = pass_hi_q | lane_wdata;
        3'd2: fail_lo_d = fail_lo_q | lane_wdata;
        3'd3: fail_hi_d = fail_hi_q | lane_wdata;
        3'd4: begin
          // Only the first done-setting write captures a code.
          if (!done_q && lane_wdata[0]) begin
            done_d = 1'b1;
            code_d = lane_wdata[31:8];
          end
        end
        3'd6: scratch_d = (scratch_q & ~mask) | lane_wdata;
        default: ;
      endcase
    end

    // Counter still counts in the cycle of the done write, then freezes.
    cycles_d = done_q ? cycles_q : cycles_q + 32'd1;
    ack_d    = req;
    rdata_d  = (req && !i_write_notread && !misal) ? rd_lane : '0;
    tpass_d  = {pass_hi_d, pass_lo_d} & ~{fail_hi_d, fail_lo_d};
  end

  // ---- register stage: request cycle -> acknowledge cycle ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dv_prev_q <= 1'b0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      pass_lo_q <= '0;
      pass_hi_q <= '0;
      fail_lo_q <= '0;
      fail_hi_q <= '0;
      scratch_q <= '0;
      cycles_q  <= '0;
      done_q    <= 1'b0;
      code_q    <= '0;
      tpass_q   <= '0;
    end else begin
      dv_prev_q <= i_bus_DV;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      pass_lo_q <= pass_lo_d;
      pass_hi_q <= pass_hi_d;
      fail_lo_q <= fail_lo_d;
      fail_hi_q <= fail_hi_d;
      scratch_q <= scratch_d;
      cycles_q  <= cycles_d;
      done_q    <= done_d;
      code_q    <= code_d;
      tpass_q   <= tpass_d;
    end
  end

  assign o_bus_data  = rdata_q;
  assign o_bus_DV    = ack_q;
  assign o_test_pass = tpass_q;
  assign o_done      = done_q;
  assign o_exit_code = code_q;
  assign o_cycles    = cycles_q;

endmodule
